mod_reduce_seq: RTL and testbench

MOD_REDUCE_SEQ -- requirements
Module: mod_reduce_seq

---
 rtl/mod_reduce_seq.sv | 119 +++++++++++
 tb/tb_mod_reduce_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// Sequential restoring reduction R = P mod M, one (or two) product bits per RUN cycle.
// Define MOD_REDUCE_RADIX4_EN to consume two bits per cycle through chained subtract stages.
module mod_reduce_seq #(
  parameter  int MW = 64,
  localparam int PW = 2*MW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] P_in,
  input  logic [MW-1:0] M_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] R,
  output logic          err
);

`ifdef MOD_REDUCE_RADIX4_EN
  localparam int SW  = PW + 1;
  localparam int BPC = 2;
`else
  localparam int SW  = PW;
  localparam int BPC = 1;
`endif
  localparam int N  = SW / BPC;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state, w_state_next;
  logic [SW-1:0] r_shift, w_shift_next;
  logic [MW-1:0] r_m,     w_m_next;
  logic [MW+1:0] r_rem,   w_rem_next;
  logic [IW-1:0] r_idx,   w_idx_next;
  logic [MW-1:0] r_res,   w_res_next;
  logic          r_err,   w_err_next;
  logic [MW+1:0] w_step;

  // Remainder stays below M, so doubling plus one bit fits MW+1 bits and one subtract suffices.
  function automatic logic [MW+1:0] f_step(input logic [MW+1:0] rem, input logic b,
                                           input logic [MW-1:0] m);
    logic [MW+1:0] t;
    t = (rem << 1) | {{(MW+1){1'b0}}, b};
    if (t >= {2'b00, m})
      t = t - {2'b00, m};
    return t;
  endfunction

`ifdef MOD_REDUCE_RADIX4_EN
  assign w_step = f_step(f_step(r_rem, r_shift[SW-1], r_m), r_shift[SW-2], r_m);
`else
  assign w_step = f_step(r_rem, r_shift[SW-1], r_m);
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign R         = r_res;
  assign err       = r_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_m     <= '0;
      r_rem   <= '0;
      r_idx   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_m     <= w_m_next;
      r_rem   <= w_rem_next;
      r_idx   <= w_idx_next;
      r_res   <= w_res_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_m_next     = r_m;
    w_rem_next   = r_rem;
    w_idx_next   = r_idx;
    w_res_next   = r_res;
    w_err_next   = r_err;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_shift_next = SW'(P_in);
          w_m_next     = M_in;
          w_rem_next   = '0;
          w_idx_next   = IW'(N - 1);
          w_res_next   = '0;
          w_err_next   = (M_in == '0);
          w_state_next = (M_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_rem_next   = w_step;
        w_shift_next = r_shift << BPC;
        if (r_idx == '0) begin
          w_res_next   = w_step[MW-1:0];
          w_state_next = DONE;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
      DONE: begin
        if (out_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Scoreboard bench for mod_reduce_seq: directed vectors, stall, reset-abort and random backpressure.
// Build with MOD_REDUCE_RADIX4_EN defined to check the two-bit-per-cycle latency.
module tb_mod_reduce_seq;
  localparam int MW = 64;
  localparam int PW = 2*MW + 1;
`ifdef MOD_REDUCE_RADIX4_EN
  localparam int N = (PW + 1) / 2;
`else
  localparam int N = PW;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] P_in;
  logic [MW-1:0] M_in;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] R;
  logic          err;

  typedef struct { logic [MW-1:0] r; logic e; } exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  mod_reduce_seq #(.MW(MW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .P_in(P_in), .M_in(M_in), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got R=%h err=%b, required no result", R, err);
      end else begin
        e = sb.pop_front();
        $display("[TB] result R=%h err=%b expected R=%h err=%b", R, err, e.r, e.e);
        if (R !== e.r || err !== e.e) begin
          fails++;
          $display("FAIL result: got R=%h err=%b, required R=%h err=%b", R, err, e.r, e.e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input logic [PW-1:0] p, input logic [MW-1:0] m,
                       input logic [MW-1:0] er, input logic ee);
    int guard = 0;
    while (!in_ready && guard < 2000) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready_timeout: got in_ready=0, required 1");
    end
    sb.push_back('{r: er, e: ee});
    in_valid = 1'b1; P_in = p; M_in = m;
    @(posedge clock); #1;
    in_valid = 1'b0; P_in = '1; M_in = '0;
  endtask

  // Edges from the accept edge until the consumer sees out_valid=1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: got out_valid=0, required 1");
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("post_handshake_out_valid", out_valid, 0);
    chk("post_handshake_in_ready", in_ready, 1);
  endtask

  logic [PW-1:0] tp [12];
  logic [MW-1:0] tm [12];
  logic [MW-1:0] tr [12];
  logic          te [12];

  initial begin
    int lat;
    int vcount;
    logic [PW-1:0] rp, rm;
    logic [MW-1:0] m;

    tp[0]  = 129'd100;            tm[0]  = 64'd7;          tr[0]  = 64'd2;   te[0]  = 0;
    tp[1]  = 129'd1 << 128;       tm[1]  = '1;             tr[1]  = 64'd1;   te[1]  = 0;
    tp[2]  = '1;                  tm[2]  = '1;             tr[2]  = 64'd1;   te[2]  = 0;
    tp[3]  = 129'd5;              tm[3]  = 64'd9;          tr[3]  = 64'd5;   te[3]  = 0;
    tp[4]  = 129'd123;            tm[4]  = 64'd0;          tr[4]  = 64'd0;   te[4]  = 1;
    tp[5]  = 129'd0;              tm[5]  = 64'd5;          tr[5]  = 64'd0;   te[5]  = 0;
    tp[6]  = '1;                  tm[6]  = 64'd1;          tr[6]  = 64'd0;   te[6]  = 0;
    tp[7]  = 129'd1 << 128;       tm[7]  = 64'd3;          tr[7]  = 64'd1;   te[7]  = 0;
    tp[8]  = 129'd1 << 64;        tm[8]  = 64'd1 << 63;    tr[8]  = 64'd0;   te[8]  = 0;
    tp[9]  = 129'd12345678901234567890; tm[9] = 64'd1000;  tr[9]  = 64'd890; te[9]  = 0;
    tp[10] = '1;                  tm[10] = 64'hFFFF_FFFF_FFFF_FFFE; tr[10] = 64'd7; te[10] = 0;
    tp[11] = '1;                  tm[11] = 64'd0;          tr[11] = 64'd0;   te[11] = 1;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; P_in = '0; M_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_R", R, 0);
    chk("reset_err", err, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(tp[i], tm[i], tr[i], te[i]);
      wait_valid(lat);
      chk($sformatf("latency_%0d", i), lat, (tm[i] == '0) ? 1 : N + 1);
      take_result();
    end

    // Stall in DONE with in_valid pulses that must be ignored.
    issue(129'd100, 64'd7, 64'd2, 1'b0);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0]; P_in = 129'd5; M_in = 64'd9;
      @(posedge clock); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_R", R, 2);
      chk("stall_err", err, 0);
    end
    in_valid = 1'b0;
    take_result();

    // Reset abort at RUN cycle 50.
    issue(129'd100, 64'd7, 64'd2, 1'b0);
    repeat (49) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    void'(sb.pop_back());
    chk("abort_run_in_ready", in_ready, 1);
    chk("abort_run_out_valid", out_valid, 0);
    chk("abort_run_R", R, 0);
    vcount = 0;
    repeat (N + 20) begin
      @(posedge clock); #1;
      if (out_valid) vcount++;
    end
    chk("abort_run_no_pulse", vcount, 0);
    issue(129'd100, 64'd7, 64'd2, 1'b0);
    wait_valid(lat);
    take_result();

    // Reset abort while a result waits in DONE.
    issue(129'd5, 64'd9, 64'd5, 1'b0);
    wait_valid(lat);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    void'(sb.pop_back());
    chk("abort_done_out_valid", out_valid, 0);
    chk("abort_done_R", R, 0);
    chk("abort_done_in_ready", in_ready, 1);

    // Random pairs with random consumer backpressure.
    for (int i = 0; i < 120; i++) begin
      rp = {$urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom};
      m  = (i % 4 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (m == '0) m = 64'd1;
      rm = PW'(m);
      issue(rp, m, 64'(rp % rm), 1'b0);
      wait_valid(lat);
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      take_result();
    end

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
